// File: rtl/pipe_credit_fifo_if.sv
// Handshake bundle for pipe_credit_fifo.
// The master modport belongs to the environment: producer, upstream pipeline and consumer.
// The slave modport belongs to the FIFO.
// CW must equal $clog2(DEPTH + 1) of the FIFO it connects to.
interface pipe_credit_fifo_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4
);
  logic          s_valid;
  logic          s_ready;
  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] credits;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output s_valid,
    output pipe_valid,
    output pipe_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data,
    input  credits,
    input  count,
    input  overflow
  );

  modport slave (
    input  s_valid,
    input  pipe_valid,
    input  pipe_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data,
    output credits,
    output count,
    output overflow
  );
endinterface

// File: rtl/pipe_credit_fifo.sv
// Credit-based elastic buffer behind a fixed-latency, enable-free pipeline.
// Issue credits guarantee that every word entering the pipeline has a FIFO slot LAT cycles later.
// The pipeline therefore never has to stall.
// Optional feature: define PIPE_CREDIT_FIFO_BYPASS_EN for a zero-latency bypass.
// With the bypass, a word arriving at an empty FIFO is presented on m_data in the same cycle.
// If that word is accepted in the same cycle, it is never written.
module pipe_credit_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LAT   = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  pipe_credit_fifo_if.slave bus
);

  localparam int unsigned   PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          bypass;
  logic          issue;
  logic          pop;
  logic          pop_fifo;
  logic          push;
  logic          empty;
  logic          full;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthC);

  // Credits come straight from a register, so m_ready never reaches s_ready combinationally.
  assign s_ready = (credits_q != '0);

`ifdef PIPE_CREDIT_FIFO_BYPASS_EN
  // An arriving word at an empty FIFO is shown to the consumer immediately.
  assign bypass  = empty && bus.pipe_valid;
  assign m_valid = !empty || bypass;
  assign m_data  = empty ? bus.pipe_data : mem_q[rd_ptr_q];
`else
  assign bypass  = 1'b0;
  assign m_valid = !empty;
  assign m_data  = mem_q[rd_ptr_q];
`endif

  // Handshake decode: credit accounting uses every delivery.
  // Storage only counts deliveries taken out of the array.
  always_comb begin
    issue    = bus.s_valid && s_ready;
    pop      = m_valid && bus.m_ready;
    pop_fifo = pop && !empty;
    // A bypassed word accepted in its arrival cycle never occupies a slot.
    push     = bus.pipe_valid && !(bypass && bus.m_ready) && (!full || pop);
  end

  // Next-state for counters, pointers and the sticky overflow flag.
  always_comb begin
    credits_d  = credits_q - CW'(issue) + CW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop_fifo);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    // DEPTH need not be a power of two, so the wrap is explicit.
    if (pop_fifo) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    // A word that finds the FIFO full with nothing leaving is lost for good.
    if (bus.pipe_valid && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state with synchronous reset.
  // Words still in flight at reset are written normally when they arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q  <= DepthC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are meaningless until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.pipe_data;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid;
  assign bus.m_data   = m_data;
  assign bus.credits  = credits_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

  // The slot guarantee needs room for every in-flight word plus the one being drained.
  a_param_legal : assert property (@(posedge clk) (DEPTH >= LAT + 1) && (DEPTH <= 256));

  // Credits above DEPTH mean the pipeline delivered words that were never issued.
  a_credits_bound : assert property (@(posedge clk) disable iff (rst) credits_q <= DepthC);

  // A stalled head must hold still until it is taken.
  a_head_stable : assert property (@(posedge clk) disable iff (rst)
    (m_valid && !bus.m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Directed bench for pipe_credit_fifo with a LAT=4 delay-chain model upstream.
module tb_pipe_credit_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 4;
  localparam int unsigned CW    = 4;
`ifdef PIPE_CREDIT_FIFO_BYPASS_EN
  localparam int FirstValid = 5 - 1;
`else
  localparam int FirstValid = 5;
`endif

  logic clk;
  logic rst;

  pipe_credit_fifo_if #(.DW(DW), .CW(CW)) bus ();

  pipe_credit_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .LAT  (LAT),
    .CW   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream pipeline model: four-stage delay chain, reset together with the DUT.
  logic [3:0]    pv;
  logic [DW-1:0] pd [4];
  logic [DW-1:0] issue_cnt;
  logic          inj_valid;
  logic [DW-1:0] inj_data;

  always @(posedge clk) begin
    if (rst) begin
      pv        <= '0;
      issue_cnt <= '0;
    end else begin
      pv    <= {pv[2:0], bus.s_valid && bus.s_ready};
      pd[0] <= issue_cnt;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
      if (bus.s_valid && bus.s_ready) issue_cnt <= issue_cnt + 1'b1;
    end
  end

  assign bus.pipe_valid = pv[3] | inj_valid;
  assign bus.pipe_data  = inj_valid ? inj_data : pd[3];

  int checks;
  int failures;
  bit inv_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample #1 after the edge.
  // Optionally check count + in-flight + credits == DEPTH.
  task automatic step();
    int infl;
    @(posedge clk);
    #1;
    if (inv_en) begin
      infl = int'(pv[0]) + int'(pv[1]) + int'(pv[2]) + int'(pv[3]);
      chk("invariant", 32'(bus.count) + 32'(bus.credits) + 32'(infl), 32'(DEPTH));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_data;
    int first_v;
    int last_v;
    int got;
    int n_iss;
    bit sready_drop;

    checks   = 0;
    failures = 0;
    inv_en   = 1'b0;
    rst      = 1'b1;
    inj_valid = 1'b0;
    inj_data  = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Reset values.
    step();
    step();
    chk("rst_credits", 32'(bus.credits), 32'd8);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    rst    = 1'b0;
    inv_en = 1'b1;

    // Streaming: 20 issues with the consumer always ready.
    exp_data    = 8'h00;
    first_v     = -1;
    last_v      = -1;
    got         = 0;
    sready_drop = 1'b0;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 20) bus.s_valid = 1'b0;
      if (i < 20 && bus.s_ready !== 1'b1) sready_drop = 1'b1;
      if (bus.m_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        chk("stream_data", 32'(bus.m_data), 32'(exp_data));
        exp_data = exp_data + 1'b1;
        got++;
      end
    end
    chk("stream_first_valid", 32'(first_v), 32'(FirstValid));
    chk("stream_words", 32'(got), 32'd20);
    chk("stream_one_per_cycle", 32'(last_v - first_v), 32'd19);
    chk("stream_s_ready_held", 32'(sready_drop), 32'd0);
    chk("stream_end_count", 32'(bus.count), 32'd0);
    chk("stream_end_credits", 32'(bus.credits), 32'd8);

    // Back-pressure: exactly 8 issues, then the FIFO fills as the pipeline drains.
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    n_iss = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.s_ready === 1'b1) n_iss++;
      step();
    end
    bus.s_valid = 1'b0;
    chk("bp_issues", 32'(n_iss), 32'd8);
    chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
    chk("bp_count", 32'(bus.count), 32'd8);
    chk("bp_credits", 32'(bus.credits), 32'd0);
    chk("bp_overflow", 32'(bus.overflow), 32'd0);

    // Drain: 8 words in order, credit back on the cycle after the first pop.
    bus.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_m_valid", 32'(bus.m_valid), 32'd1);
      chk("drain_data", 32'(bus.m_data), 32'(exp_data));
      exp_data = exp_data + 1'b1;
      step();
      if (k == 0) chk("drain_s_ready", 32'(bus.s_ready), 32'd1);
    end
    chk("drain_count", 32'(bus.count), 32'd0);
    chk("drain_m_valid_low", 32'(bus.m_valid), 32'd0);
    chk("drain_credits", 32'(bus.credits), 32'd8);

    // Refill to full for the injection cases.
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 12; i++) step();
    bus.s_valid = 1'b0;
    chk("refill_count", 32'(bus.count), 32'd8);
    chk("refill_head", 32'(bus.m_data), 32'(exp_data));

    // Full with simultaneous pop: the injected word is stored behind the others.
    inv_en      = 1'b0;
    inj_valid   = 1'b1;
    inj_data    = 8'hA5;
    bus.m_ready = 1'b1;
    step();
    inj_valid   = 1'b0;
    bus.m_ready = 1'b0;
    exp_data    = exp_data + 1'b1;
    chk("fullpop_count", 32'(bus.count), 32'd8);
    chk("fullpop_overflow", 32'(bus.overflow), 32'd0);
    chk("fullpop_head", 32'(bus.m_data), 32'(exp_data));
    chk("fullpop_credits", 32'(bus.credits), 32'd1);

    // Overflow: full, no pop, word arrives anyway.
    inj_valid = 1'b1;
    inj_data  = 8'h5A;
    step();
    inj_valid = 1'b0;
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_head", 32'(bus.m_data), 32'(exp_data));

    // Pop the seven older words; the next head must be 0xA5, not the dropped 0x5A.
    bus.m_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("ovf_drain_data", 32'(bus.m_data), 32'(exp_data));
      exp_data = exp_data + 1'b1;
      step();
    end
    bus.m_ready = 1'b0;
    chk("ovf_tail_data", 32'(bus.m_data), 32'h0000_00A5);
    chk("ovf_tail_count", 32'(bus.count), 32'd1);
    repeat (3) step();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset clears the sticky flag.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_overflow", 32'(bus.overflow), 32'd0);
    chk("rst2_count", 32'(bus.count), 32'd0);
    chk("rst2_credits", 32'(bus.credits), 32'd8);
    inv_en = 1'b1;

    // Mid-operation reset with 5 stored and 3 in flight.
    bus.s_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    bus.s_valid = 1'b0;
    step();
    chk("mid_count", 32'(bus.count), 32'd5);
    chk("mid_credits", 32'(bus.credits), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_credits", 32'(bus.credits), 32'd8);
    chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);

    // Short stream after reset keeps the invariant and drains cleanly.
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    repeat (3) step();
    bus.s_valid = 1'b0;
    repeat (8) step();
    chk("post_count", 32'(bus.count), 32'd0);
    chk("post_credits", 32'(bus.credits), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
